// File: rtl/upsample_window_buf.sv
// ---------------------------------------------------------------------------
// upsample_window_buf
//
// Streaming 2x2 window generator feeding the interpolation stage. Pixels of a
// square frame arrive in raster order over a valid/ready handshake. One
// previous row is kept in a line buffer so that, for every accepted pixel at
// (r,c), a window {tl, tr, bl, br} covering (r-1..r, c-1..c) is emitted one
// cycle later. Missing neighbours on the top row and left column are
// replaced by replicating the nearest available pixel.
//
// Parameters
//   DATA_W    pixel width in bits
//   MAX_COLS  line-buffer depth and largest frame side (power of two, >= 4)
//   CW        row/column index width, derived from MAX_COLS
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   size_sel   frame side select: side = min(4 << size_sel, MAX_COLS)
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel this cycle
//   in_data    input pixel
//   out_valid  window valid
//   out_ready  downstream accepts the window
//   out_tl/tr/bl/br  window pixels (br is the pixel that produced it)
//   out_col/out_row  frame position of out_br
//   out_sof    window is at (0,0)
//   out_eol    window is at the last column
//   out_eof    window is at the last column of the last row
// ---------------------------------------------------------------------------
module upsample_window_buf #(
   parameter int DATA_W   = 16,
   parameter int MAX_COLS = 128,
   parameter int CW       = $clog2(MAX_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        size_sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_tl,
   output logic [DATA_W-1:0] out_tr,
   output logic [DATA_W-1:0] out_bl,
   output logic [DATA_W-1:0] out_br,
   output logic [CW-1:0]     out_col,
   output logic [CW-1:0]     out_row,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof
);

   // Largest size_sel that still yields a side below MAX_COLS is
   // log2(MAX_COLS/4) - 1; anything at or above log2(MAX_COLS/4) clamps.
   localparam logic [31:0] SEL_CLAMP = 32'(CW - 2);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   // Frame side is held as (N - 1): the last valid index. Reset value 3
   // corresponds to a side of 4.
   logic [CW-1:0]     r_last;
   logic [CW-1:0]     r_col;
   logic [CW-1:0]     r_row;

   // Left-neighbour registers: previous accepted pixel (for bl) and the
   // line-buffer word read alongside it (for tl).
   logic [DATA_W-1:0] r_prev_pix;
   logic [DATA_W-1:0] r_prev_top;

   // One row of history. Deliberately not reset: on row 0 every top term
   // is replaced by the current row, so stale words are never visible.
   logic [DATA_W-1:0] r_line [MAX_COLS];

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_tl;
   logic [DATA_W-1:0] r_out_tr;
   logic [DATA_W-1:0] r_out_bl;
   logic [DATA_W-1:0] r_out_br;
   logic [CW-1:0]     r_out_col;
   logic [CW-1:0]     r_out_row;
   logic              r_out_sof;
   logic              r_out_eol;
   logic              r_out_eof;

   // ------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------
   logic              w_in_ready;
   logic              w_accept;
   logic              w_load;
   logic              w_first;
   logic              w_row0;
   logic              w_col0;
   logic [CW-1:0]     w_last_dec;
   logic [CW-1:0]     w_last;
   logic              w_col_last;
   logic              w_row_last;
   logic [DATA_W-1:0] w_top_raw;
   logic [DATA_W-1:0] w_tl;
   logic [DATA_W-1:0] w_tr;
   logic [DATA_W-1:0] w_bl;

   // The output register is the only storage stage, so a new pixel can be
   // taken whenever the current window is absent or leaving this cycle.
   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   // Reset wins over a same-cycle accept: nothing is written or counted.
   assign w_load     = w_accept && !rst;

   assign w_row0  = (r_row == '0);
   assign w_col0  = (r_col == '0);
   assign w_first = w_row0 && w_col0;

   // Decode size_sel into the last index of the frame, clamping to the
   // line-buffer depth.
   always_comb begin
      w_last_dec = {CW{1'b1}};
      if (32'(size_sel) < SEL_CLAMP) begin
         w_last_dec = CW'((32'd4 << size_sel) - 32'd1);
      end
   end

   // The first pixel of a frame already runs under the newly decoded side;
   // every later pixel uses the latched side, so mid-frame size_sel changes
   // are ignored.
   assign w_last     = w_first ? w_last_dec : r_last;
   assign w_col_last = (r_col == w_last);
   assign w_row_last = (r_row == w_last);

   // Line buffer still holds the previous row at [c] because this cycle's
   // write only lands on the clock edge.
   assign w_top_raw = r_line[r_col];

   // Edge replication:
   //   left column -> bl from br, tl from tr
   //   top row     -> tr from br, tl from bl
   assign w_bl = w_col0 ? in_data : r_prev_pix;
   assign w_tr = w_row0 ? in_data : w_top_raw;

   always_comb begin
      w_tl = r_prev_top;
      if (w_row0) begin
         w_tl = w_bl;
      end else if (w_col0) begin
         w_tl = w_top_raw;
      end
   end

   // ------------------------------------------------------------------
   // Position counters, frame-size latch and left-neighbour registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= CW'(3);
         r_col      <= '0;
         r_row      <= '0;
         r_prev_pix <= '0;
         r_prev_top <= '0;
      end else if (w_accept) begin
         r_prev_pix <= in_data;
         r_prev_top <= w_top_raw;
         if (w_first) begin
            r_last <= w_last_dec;
         end
         if (w_col_last) begin
            r_col <= '0;
            // Last pixel of the last row closes the frame.
            r_row <= w_row_last ? '0 : r_row + CW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Line buffer write (no reset so it maps onto block RAM)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_line[r_col] <= in_data;
      end
   end

   // ------------------------------------------------------------------
   // Output register stage
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_tl    <= '0;
         r_out_tr    <= '0;
         r_out_bl    <= '0;
         r_out_br    <= '0;
         r_out_col   <= '0;
         r_out_row   <= '0;
         r_out_sof   <= 1'b0;
         r_out_eol   <= 1'b0;
         r_out_eof   <= 1'b0;
      end else if (w_accept) begin
         // Covers both a fresh window and drain-plus-refill in one cycle.
         r_out_valid <= 1'b1;
         r_out_tl    <= w_tl;
         r_out_tr    <= w_tr;
         r_out_bl    <= w_bl;
         r_out_br    <= in_data;
         r_out_col   <= r_col;
         r_out_row   <= r_row;
         r_out_sof   <= w_first;
         r_out_eol   <= w_col_last;
         r_out_eof   <= w_col_last && w_row_last;
      end else if (out_ready) begin
         // Window consumed with nothing to replace it; data words are left
         // as they were since they are qualified by out_valid.
         r_out_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_tl    = r_out_tl;
   assign out_tr    = r_out_tr;
   assign out_bl    = r_out_bl;
   assign out_br    = r_out_br;
   assign out_col   = r_out_col;
   assign out_row   = r_out_row;
   assign out_sof   = r_out_sof;
   assign out_eol   = r_out_eol;
   assign out_eof   = r_out_eof;

endmodule

// File: tb/tb_upsample_window_buf.sv
// ---------------------------------------------------------------------------
// tb_upsample_window_buf
//
// Directed bench for upsample_window_buf (DATA_W = 16, MAX_COLS = 128).
// A reference frame store rebuilds every window from absolute frame
// coordinates with clamped neighbour indices, and the stream driver checks
// each presented window, handshake timing and stall behaviour. Directed
// steps add hand-computed windows and frame-level counts.
// ---------------------------------------------------------------------------
module tb_upsample_window_buf;

   localparam int DW = 16;
   localparam int MC = 128;
   localparam int CWT = 7;

   logic            clk;
   logic            rst;
   logic [2:0]      size_sel;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_tl;
   logic [DW-1:0]   out_tr;
   logic [DW-1:0]   out_bl;
   logic [DW-1:0]   out_br;
   logic [CWT-1:0]  out_col;
   logic [CWT-1:0]  out_row;
   logic            out_sof;
   logic            out_eol;
   logic            out_eof;

   upsample_window_buf #(
      .DATA_W   (DW),
      .MAX_COLS (MC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .size_sel  (size_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tl    (out_tl),
      .out_tr    (out_tr),
      .out_bl    (out_bl),
      .out_br    (out_br),
      .out_col   (out_col),
      .out_row   (out_row),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .out_eof   (out_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [DW-1:0] img [MC][MC];
   int            m_r = 0;
   int            m_c = 0;
   int            m_n = 4;
   logic [95:0]   exp_q [$];
   logic [95:0]   got   [$];
   logic [DW-1:0] in_q  [$];

   // Per-run statistics
   int wins, sent, sof_cnt, eof_cnt, first_eol_col, eof_at;
   int stall_idx, stall_left, stall_hit;
   int chg_at;
   logic [2:0] chg_val;
   logic [95:0] hold_val;
   bit prev_acc, prev_drain;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [95:0] pk(input logic [15:0] tl, input logic [15:0] tr,
                                      input logic [15:0] bl, input logic [15:0] br,
                                      input logic [6:0] row, input logic [6:0] col,
                                      input logic s, input logic l, input logic f);
      return {15'b0, tl, tr, bl, br, row, col, s, l, f};
   endfunction

   function automatic int dec_n(input logic [2:0] sel);
      case (sel)
         3'd0: return 4;
         3'd1: return 8;
         3'd2: return 16;
         3'd3: return 32;
         3'd4: return 64;
         default: return 128;
      endcase
   endfunction

   task automatic model_push(input logic [15:0] d);
      int rt;
      int cl;
      logic s, l, f;
      if (m_r == 0 && m_c == 0) m_n = dec_n(size_sel);
      img[m_r][m_c] = d;
      rt = (m_r == 0) ? 0 : m_r - 1;
      cl = (m_c == 0) ? 0 : m_c - 1;
      s = (m_r == 0) && (m_c == 0);
      l = (m_c == m_n - 1);
      f = l && (m_r == m_n - 1);
      exp_q.push_back(pk(img[rt][cl], img[rt][m_c], img[m_r][cl], d,
                         7'(m_r), 7'(m_c), s, l, f));
      if (l) begin
         m_c = 0;
         m_r = f ? 0 : m_r + 1;
      end else begin
         m_c++;
      end
   endtask

   task automatic clear_stats();
      got.delete();
      wins = 0; sent = 0; sof_cnt = 0; eof_cnt = 0;
      first_eol_col = -1; eof_at = -1;
      stall_idx = -1; stall_left = 0; stall_hit = 0;
      chg_at = -1; chg_val = 3'd0;
   endtask

   task automatic model_reset();
      m_r = 0; m_c = 0;
      exp_q.delete();
      prev_acc = 0; prev_drain = 0;
   endtask

   function automatic logic [95:0] obs_win();
      return pk(out_tl, out_tr, out_bl, out_br, out_row, out_col, out_sof, out_eol, out_eof);
   endfunction

   // Drives the queued pixels with the given valid/ready probabilities (%)
   // and checks everything the output presents until the pipe is empty.
   task automatic run_stream(input int pv, input int pr, input int budget);
      int cyc;
      logic [95:0] obs;
      bit stalled_now;
      cyc = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0 || out_valid) && cyc < budget) begin
         if (prev_acc) chk("latency_valid", 96'(out_valid), 96'(1));
         else if (prev_drain) chk("drain_clear", 96'(out_valid), 96'(0));
         if (chg_at >= 0 && sent == chg_at) size_sel = chg_val;
         in_valid  = (in_q.size() > 0) && ($urandom_range(99) < pv);
         in_data   = in_valid ? in_q[0] : 16'($urandom);
         out_ready = ($urandom_range(99) < pr);
         stalled_now = 0;
         if (out_valid && stall_left > 0 && wins == stall_idx) begin
            out_ready = 1'b0;
            stall_left--;
            stall_hit++;
            stalled_now = 1;
         end
         #1;
         if (out_valid) begin
            obs = obs_win();
            if (exp_q.size() == 0) chk("unexpected_window", obs, 96'(0));
            else chk("window", obs, exp_q[0]);
            if (stalled_now) chk("stall_hold", obs, hold_val);
            if (!out_ready) chk("stall_in_ready", 96'(in_ready), 96'(0));
            if (out_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               got.push_back(obs);
               wins++;
               if (out_sof) sof_cnt++;
               if (out_eol && first_eol_col < 0) first_eol_col = int'(out_col);
               if (out_eof) begin
                  eof_cnt++;
                  if (eof_at < 0) eof_at = wins;
               end
            end
         end
         prev_drain = out_valid && out_ready;
         prev_acc   = in_valid && in_ready;
         if (prev_acc) begin
            model_push(in_data);
            void'(in_q.pop_front());
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_drained", 96'((in_q.size() == 0) && (exp_q.size() == 0) && !out_valid), 96'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("reset_valid", 96'(out_valid), 96'(0));
      chk("reset_outputs", obs_win(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("reset_in_ready", 96'(in_ready), 96'(1));
   endtask

   initial begin
      rst = 1'b1;
      size_sel = 3'd0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      prev_acc = 0;
      prev_drain = 0;
      hold_val = '0;
      clear_stats();
      @(posedge clk);
      #1;
      do_reset();

      // Step 1: 4x4 frame, data = 16r + c, continuous flow
      clear_stats();
      size_sel = 3'd0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) in_q.push_back(16'(16 * r + c));
      run_stream(100, 100, 200);
      chk("t1_count", 96'(wins), 96'(16));
      chk("t1_win_0_2", got[2], pk(16'h01, 16'h02, 16'h01, 16'h02, 7'd0, 7'd2, 0, 0, 0));
      chk("t1_win_1_1", got[5], pk(16'h00, 16'h01, 16'h10, 16'h11, 7'd1, 7'd1, 0, 0, 0));
      chk("t1_win_2_0", got[8], pk(16'h10, 16'h10, 16'h20, 16'h20, 7'd2, 7'd0, 0, 0, 0));
      chk("t1_win_3_3", got[15], pk(16'h22, 16'h23, 16'h32, 16'h33, 7'd3, 7'd3, 0, 1, 1));
      chk("t1_eof_cnt", 96'(eof_cnt), 96'(1));
      chk("t1_eof_at", 96'(eof_at), 96'(16));
      chk("t1_sof_cnt", 96'(sof_cnt), 96'(1));

      // Step 2: same frame, 3-cycle stall while window (1,2) is presented
      clear_stats();
      stall_idx = 6;
      stall_left = 3;
      hold_val = pk(16'h01, 16'h02, 16'h11, 16'h12, 7'd1, 7'd2, 0, 0, 0);
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) in_q.push_back(16'(16 * r + c));
      run_stream(100, 100, 200);
      chk("t2_count", 96'(wins), 96'(16));
      chk("t2_stall_cycles", 96'(stall_hit), 96'(3));
      chk("t2_win_1_2", got[6], hold_val);

      // Step 3: 8x8 frame with size_sel dropped to 0 after 5 pixels, then 4x4
      clear_stats();
      size_sel = 3'd1;
      chg_at = 5;
      chg_val = 3'd0;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_q.push_back(16'(16 * r + c));
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) in_q.push_back(16'(16 * r + c));
      run_stream(100, 100, 500);
      chk("t3_count", 96'(wins), 96'(80));
      chk("t3_first_eol_col", 96'(first_eol_col), 96'(7));
      chk("t3_eof_at", 96'(eof_at), 96'(64));
      chk("t3_eof_cnt", 96'(eof_cnt), 96'(2));
      chk("t3_sof_cnt", 96'(sof_cnt), 96'(2));
      chk("t3_last_win", got[79], pk(16'h22, 16'h23, 16'h32, 16'h33, 7'd3, 7'd3, 0, 1, 1));

      // Step 4: size_sel = 7 clamps to 128x128
      clear_stats();
      size_sel = 3'd7;
      for (int i = 0; i < MC * MC; i++) in_q.push_back(16'(i));
      run_stream(100, 100, 20000);
      chk("t4_first_eol_col", 96'(first_eol_col), 96'(127));
      chk("t4_eof_at", 96'(eof_at), 96'(16384));
      chk("t4_count", 96'(wins), 96'(16384));

      // Step 5: reset while pixel (2,1) of a 4x4 frame is offered
      clear_stats();
      size_sel = 3'd0;
      for (int i = 0; i < 9; i++) in_q.push_back(16'(16 * (i / 4) + (i % 4)));
      run_stream(100, 100, 100);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h21;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      model_reset();
      chk("t5_valid_after_rst", 96'(out_valid), 96'(0));
      chk("t5_outputs_after_rst", obs_win(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      clear_stats();
      in_q.push_back(16'hAA);
      run_stream(100, 100, 50);
      chk("t5_restart_win", got[0], pk(16'hAA, 16'hAA, 16'hAA, 16'hAA, 7'd0, 7'd0, 1, 0, 0));

      // Step 6: three 16x16 frames with random valid/ready
      do_reset();
      clear_stats();
      size_sel = 3'd2;
      for (int i = 0; i < 3 * 256; i++) in_q.push_back(16'($urandom));
      run_stream(60, 60, 10000);
      chk("t6_count", 96'(wins), 96'(768));
      chk("t6_sof_cnt", 96'(sof_cnt), 96'(3));
      chk("t6_eof_cnt", 96'(eof_cnt), 96'(3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/upsample_window_buf.md
# upsample_window_buf

Streaming 2x2 window generator for the upsampling datapath. It accepts a square feature-map frame in raster order over a valid/ready handshake and stores one previous row in a line buffer. For every accepted pixel it emits one 2x2 neighbourhood (top-left, top-right, bottom-left, bottom-right) with edge replication, plus position and framing flags, to the interpolation stage. It generalises the fixed 16-bit, 128-column, 2-phase input register with parametrised width and depth, a clamped frame-size decode, full backpressure, frame-boundary size latching and edge handling.

## Interface
- DATA_W, 16, pixel width in bits
- MAX_COLS, 128, line-buffer depth and maximum frame side; power of two, at least 4
- CW, $clog2(MAX_COLS), width of the row/column indices (derived; do not override)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- size_sel  in  3  frame side = min(4 << size_sel, MAX_COLS)
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  DATA_W  input pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts the window
- out_tl, out_tr, out_bl, out_br  out  DATA_W each  window pixels
- out_col, out_row  out  CW each  position of out_br in the frame
- out_sof  out  1  window is at (0,0)
- out_eol  out  1  window is at the last column
- out_eof  out  1  window is at the last column of the last row

## Operation
- Effective side N = min(4 << size_sel, MAX_COLS). size_sel 0..5 gives 4, 8, 16, 32, 64, 128. Values 6 and 7 clamp to MAX_COLS.
- N is latched into n_reg only when an input is accepted at (row 0, col 0). Changes to size_sel mid-frame have no effect until the next frame starts.
- Accept condition: in_valid && in_ready. Each accepted pixel at (r,c) produces exactly one window.
- Window for an accepted pixel at (r,c):
  - br = in_data
  - bl = current-row pixel at c-1
  - tr = line buffer entry [c], read before this cycle's write
  - tl = line buffer entry [c-1]
- Edge replication:
  - c = 0: bl = br and tl = tr.
  - r = 0: tl = bl and tr = br.
  - (0,0): all four window outputs equal in_data.
- Line buffer:
  - MAX_COLS x DATA_W array, combinational read, written at [c] with in_data on accept.
  - Not reset. Row-0 replication makes stale contents unobservable.
- Left-neighbour registers hold the previous accepted in_data and the previous tr value for the bl and tl terms.
- Counters on accept:
  - c increments.
  - At c = N-1, c wraps to 0 and r increments.
  - At r = N-1 and c = N-1, r wraps to 0 and the frame ends.
- Flags: out_sof = (r,c) == (0,0). out_eol = (c == N-1). out_eof = out_eol && (r == N-1).

## Timing
- Single output register stage. A window appears on the output one cycle after its pixel is accepted.
- in_ready = !out_valid || out_ready (combinational). The design has no bubbles, so throughput is 1 pixel per cycle under continuous out_ready.
- On accept, all output registers load and out_valid is set to 1.
- When out_valid && out_ready is true with no new accept, out_valid clears to 0.
- While out_valid && !out_ready:
  - All outputs hold stable.
  - in_ready is 0.
  - Counters and the line buffer do not change.
- Reset behaviour (next edge after rst is high):
  - out_valid, all data outputs, out_col, out_row and the three flags go to 0.
  - r and c go to 0.
  - n_reg goes to 4.
  - The left-neighbour registers go to 0.
- Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0). rst has priority over an accept in the same cycle.
- Simultaneous output drain and new accept in one cycle: out_valid stays 1 and the new window replaces the old one.

## Test plan
- Frame of N = 4 (size_sel = 0), in_data = 16r + c, out_ready held at 1:
  - 16 windows, each one cycle after its input.
  - Window (1,1): tl = 0x00, tr = 0x01, bl = 0x10, br = 0x11.
  - Window (0,2): tl = bl = 0x01, tr = br = 0x02.
  - Window (2,0): tl = tr = 0x10, bl = br = 0x20.
  - out_eof is set only on (3,3).
- Backpressure: same frame, with out_ready low for 3 cycles at window (1,2):
  - Outputs hold 0x01/0x02/0x11/0x12.
  - in_ready stays 0 for all 3 cycles.
  - No input pixel is lost or duplicated; the total is 16 windows.
- Size latch: size_sel = 1, then changed to 0 after 5 pixels:
  - The frame still runs 8x8 (64 windows), with out_eol on c = 7.
  - The next frame runs 4x4.
- Clamp: size_sel = 7 with MAX_COLS = 128:
  - N = 128; out_eol first appears at out_col = 127.
  - out_eof appears after 16384 windows.
- Reset mid-frame: assert rst at pixel (2,1) of a 4x4 frame, then restart with value 0xAA:
  - out_valid is 0 the cycle after reset.
  - The first new window is at (0,0) with all four pixels 0xAA and out_sof = 1.
- Random valid/ready toggling over three back-to-back 16x16 frames:
  - Windows match a golden model in count, order and values.
  - out_sof occurs once per frame.
